// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer/debouncer.
// Imported by sync_debounce and sync_debounce_channel.
package sync_pkg;

    localparam int SYNC_BITS_DEF       = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Debounce counter width: wide enough for 0..n-1, never below one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: flop synchronizer chain, debounce counter and registered
// rise/fall pulse generation.
module sync_debounce_channel
    import sync_pkg::*;
#(
    parameter int SYNC_BITS       = SYNC_BITS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    input  logic bypass,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_BITS-1:0] sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 s;

    assign s = sync_q[SYNC_BITS-1];

    // Next-state: shift the synchronizer, run the mismatch counter, derive edges.
    always_comb begin
        sync_d = {sync_q[SYNC_BITS-2:0], din};
        cnt_d  = '0;
        out_d  = out_q;
        if (bypass) begin
            out_d = s;
        end else if (s != out_q) begin
            if (cnt_q == CNT_MAX) begin
                out_d = s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    // State registers; reset clears everything, including a partial count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Bank of independent synchronizer + debounce channels.
// Define SYNC_DEBOUNCE_BYPASS_EN to add a global bypass input.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_BITS       = SYNC_BITS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clock,
    input  logic                reset,
`ifdef SYNC_DEBOUNCE_BYPASS_EN
    input  logic                bypass,
`endif
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    logic bypass_w;

`ifdef SYNC_DEBOUNCE_BYPASS_EN
    assign bypass_w = bypass;
`else
    assign bypass_w = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_debounce_channel #(
            .SYNC_BITS       (SYNC_BITS),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .din    (in[i]),
            .bypass (bypass_w),
            .dout   (out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce with SYNC_BITS=3, DEBOUNCE_CYCLES=4.
// Expected levels per cycle are hand-computed in the directed sequences.
module tb_sync_debounce;

    logic       clock;
    logic       reset;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
`ifdef SYNC_DEBOUNCE_BYPASS_EN
    logic       bypass;
`endif

    typedef struct {
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] prev_eo = 4'b0000;

    sync_debounce #(
        .CHANNELS        (4),
        .SYNC_BITS       (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
`ifdef SYNC_DEBOUNCE_BYPASS_EN
        .bypass(bypass),
`endif
        .in    (in),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: the DUT presents {out,rise,fall} every cycle; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({out, rise, fall} !== e.v) begin
                    errors++;
                    $display("FAIL %s: got out=%b rise=%b fall=%b want out=%b rise=%b fall=%b",
                             e.tag, out, rise, fall, e.v[11:8], e.v[7:4], e.v[3:0]);
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input logic r, input logic [3:0] i,
                        input logic [3:0] eo, input string tag);
        exp_t e;
        logic [3:0] er, ef;
        @(negedge clock);
        reset = r;
        in    = i;
        er    = r ? 4'b0000 : (eo & ~prev_eo);
        ef    = r ? 4'b0000 : (~eo & prev_eo);
        e.v   = {eo, er, ef};
        e.tag = tag;
        sb.push_back(e);
        prev_eo = eo;
    endtask

    initial begin
        reset = 1'b1;
        in    = 4'b0000;
`ifdef SYNC_DEBOUNCE_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (2) @(posedge clock);

        // Reset state, then idle inputs.
        for (int k = 0; k < 2; k++) step(1'b1, 4'b0000, 4'b0000, "reset");
        for (int k = 0; k < 20; k++) step(1'b0, 4'b0000, 4'b0000, "idle");

        // ch0 rises: out after edge 7.
        for (int k = 1; k <= 10; k++)
            step(1'b0, 4'b0001, (k >= 7) ? 4'b0001 : 4'b0000, "ch0_rise");

        // ch1 glitch of 3 cycles: filtered out.
        for (int k = 1; k <= 12; k++)
            step(1'b0, (k <= 3) ? 4'b0011 : 4'b0001, 4'b0001, "ch1_glitch");

        // ch1 pulse of 4 cycles: out high edges 7..10, falls at 11.
        for (int k = 1; k <= 14; k++)
            step(1'b0, (k <= 4) ? 4'b0011 : 4'b0001,
                 (k >= 7 && k <= 10) ? 4'b0011 : 4'b0001, "ch1_pulse");

        // ch2 bounce 1,0,1,1,...: count restarts, out at edge 9.
        for (int k = 1; k <= 12; k++)
            step(1'b0, (k == 2) ? 4'b0001 : 4'b0101,
                 (k >= 9) ? 4'b0101 : 4'b0001, "ch2_bounce");

        // Drop ch0/ch2 together.
        for (int k = 1; k <= 10; k++)
            step(1'b0, 4'b0000, (k >= 7) ? 4'b0000 : 4'b0101, "drop_02");

        // All four rise together.
        for (int k = 1; k <= 10; k++)
            step(1'b0, 4'b1111, (k >= 7) ? 4'b1111 : 4'b0000, "all_rise");

        // All four fall together.
        for (int k = 1; k <= 10; k++)
            step(1'b0, 4'b0000, (k >= 7) ? 4'b0000 : 4'b1111, "all_fall");

        // ch3 reset at count 2, then full latency again from step 7.
        for (int k = 1; k <= 5; k++)
            step(1'b0, 4'b1000, 4'b0000, "ch3_precount");
        step(1'b1, 4'b1000, 4'b0000, "ch3_reset");
        for (int k = 1; k <= 8; k++)
            step(1'b0, 4'b1000, (k >= 7) ? 4'b1000 : 4'b0000, "ch3_relatch");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
